// File: rtl/bsg_tag_packet_tx_pkg.sv
// bsg_tag_tx_pkg: types and helpers shared by the bsg_tag serial transmitter
// RTL and its bench.
//   state_e    : transmitter frame states
//   frame_bits : frame length in bit periods for a given field layout
package bsg_tag_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ID,
    DNR,
    LEN,
    PAYLOAD,
    GAP
  } state_e;

  // start + id + data_not_reset + len + payload + gap, in bit periods
  function automatic int frame_bits(int id_w, int lg_w, int len, int gap_bits);
    return 2 + id_w + lg_w + len + gap_bits;
  endfunction

endpackage

// File: rtl/bsg_tag_packet_tx_if.sv
// bsg_tag_packet_tx_if: valid/ready request bundle for one tag write.
//   v, ready        : handshake (accept on v & ready)
//   id              : destination node id
//   data_not_reset  : 1 = data write, 0 = client reset packet
//   len             : payload bit count
//   payload         : payload, bit 0 sent first
// master drives the request; slave (the transmitter) drives ready.
interface bsg_tag_packet_tx_if #(
  parameter int id_w       = 4,
  parameter int lg_width_p = 4
);
  localparam int payload_w = (1 << lg_width_p) - 1;

  logic                  v;
  logic                  ready;
  logic [id_w-1:0]       id;
  logic                  data_not_reset;
  logic [lg_width_p-1:0] len;
  logic [payload_w-1:0]  payload;

  modport master (output v, id, data_not_reset, len, payload, input ready);
  modport slave  (input v, id, data_not_reset, len, payload, output ready);
endinterface

// File: rtl/bsg_tag_packet_tx_bit_timer.sv
// bsg_tag_bit_timer: bit-period counter for the tag transmitter.
//   clk_i, reset_i : clock, async active-high reset
//   en_i           : count while a frame is in progress; held at 0 otherwise
//   load_i         : restart the period at count 0
//   bit_end_o      : one-cycle pulse on the last cycle of each bit period
module bsg_tag_bit_timer #(
  parameter int bit_cycles_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic load_i,
  output logic bit_end_o
);
  localparam int w = (bit_cycles_p > 1) ? $clog2(bit_cycles_p) : 1;
  localparam logic [w-1:0] last_c = w'(bit_cycles_p - 1);

  logic [w-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || !en_i)     cnt_d = '0;
    else if (cnt_q == last_c) cnt_d = '0;
    else                      cnt_d = cnt_q + w'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // with bit_cycles_p == 1 the count is always 0, so every enabled cycle ends a bit
  assign bit_end_o = en_i & ~load_i & (cnt_q == last_c);

endmodule

// File: rtl/bsg_tag_packet_tx.sv
// bsg_tag_packet_tx: serialises one bsg_tag write per handshake onto tag_data_o.
// Frame: start(1), id LSB first, data_not_reset, len LSB first,
// payload LSB first (len bits), gap_bits_p zeros. Each bit held bit_cycles_p cycles.
//   clk_i, reset_i : clock, async active-high reset
//   req_if         : request bundle (slave side)
//   tag_data_o     : registered serial line, idle 0
//   busy_o         : frame or gap in progress
module bsg_tag_packet_tx
  import bsg_tag_tx_pkg::*;
#(
  parameter int els_p        = 16,
  parameter int lg_width_p   = 4,
  parameter int bit_cycles_p = 4,
  parameter int gap_bits_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  bsg_tag_packet_tx_if.slave req_if,
  output logic               tag_data_o,
  output logic               busy_o
);
  localparam int id_w      = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int payload_w = (1 << lg_width_p) - 1;
  localparam int cnt_w     = $clog2(payload_w + id_w + lg_width_p + gap_bits_p + 2);
  localparam logic [cnt_w-1:0] one_c = cnt_w'(1);

  state_e                state_q;
  logic [id_w-1:0]       id_q;
  logic                  dnr_q;
  logic [lg_width_p-1:0] len_q;
  logic [lg_width_p-1:0] plen_q;  // unshifted copy of len, drives payload count
  logic [payload_w-1:0]  pay_q;
  logic [cnt_w-1:0]      fcnt_q;
  logic                  tag_q;

  logic [id_w-1:0]       id_d;
  logic [lg_width_p-1:0] len_d;
  logic [payload_w-1:0]  pay_d;
  logic                  hs, bit_end, last_bit;

  assign req_if.ready = (state_q == IDLE);
  assign hs           = req_if.v & req_if.ready;
  assign busy_o       = (state_q != IDLE);
  assign tag_data_o   = tag_q;

  assign id_d     = id_q >> 1;
  assign len_d    = len_q >> 1;
  assign pay_d    = pay_q >> 1;
  assign last_bit = bit_end & (fcnt_q == one_c);

  bsg_tag_bit_timer #(.bit_cycles_p(bit_cycles_p)) timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (busy_o),
    .load_i   (hs),
    .bit_end_o(bit_end)
  );

  // the outgoing bit is loaded into tag_q on the same edge that enters or
  // advances a field, so the line always carries the current field LSB
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      dnr_q   <= 1'b0;
      len_q   <= '0;
      plen_q  <= '0;
      pay_q   <= '0;
      fcnt_q  <= '0;
      tag_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tag_q <= 1'b0;
          if (hs) begin
            id_q    <= req_if.id;
            dnr_q   <= req_if.data_not_reset;
            len_q   <= req_if.len;
            plen_q  <= req_if.len;
            pay_q   <= req_if.payload;
            fcnt_q  <= one_c;
            tag_q   <= 1'b1;
            state_q <= START;
          end
        end
        START: if (bit_end) begin
          state_q <= ID;
          fcnt_q  <= cnt_w'(id_w);
          tag_q   <= id_q[0];
        end
        ID: if (bit_end) begin
          id_q <= id_d;
          if (last_bit) begin
            state_q <= DNR;
            fcnt_q  <= one_c;
            tag_q   <= dnr_q;
          end else begin
            fcnt_q <= fcnt_q - one_c;
            tag_q  <= id_d[0];
          end
        end
        DNR: if (bit_end) begin
          state_q <= LEN;
          fcnt_q  <= cnt_w'(lg_width_p);
          tag_q   <= len_q[0];
        end
        LEN: if (bit_end) begin
          len_q <= len_d;
          if (last_bit) begin
            if (plen_q == '0) begin
              state_q <= GAP;
              fcnt_q  <= cnt_w'(gap_bits_p);
              tag_q   <= 1'b0;
            end else begin
              state_q <= PAYLOAD;
              fcnt_q  <= cnt_w'(plen_q);
              tag_q   <= pay_q[0];
            end
          end else begin
            fcnt_q <= fcnt_q - one_c;
            tag_q  <= len_d[0];
          end
        end
        PAYLOAD: if (bit_end) begin
          pay_q <= pay_d;
          if (last_bit) begin
            state_q <= GAP;
            fcnt_q  <= cnt_w'(gap_bits_p);
            tag_q   <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q - one_c;
            tag_q  <= pay_d[0];
          end
        end
        GAP: if (bit_end) begin
          tag_q <= 1'b0;
          if (last_bit) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q - one_c;
          end
        end
        default: begin
          state_q <= IDLE;
          tag_q   <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // frame occupancy must match the field layout exactly
  logic [15:0] busy_cycles_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     busy_cycles_q <= '0;
    else if (hs)     busy_cycles_q <= '0;
    else if (busy_o) busy_cycles_q <= busy_cycles_q + 16'd1;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == GAP && last_bit)
      assert (int'(busy_cycles_q) + 1 ==
              bit_cycles_p * frame_bits(id_w, lg_width_p, int'(plen_q), gap_bits_p));
  end
`endif

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
module tb_bsg_tag_packet_tx;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  bsg_tag_packet_tx_if #(.id_w(4), .lg_width_p(4)) if0 ();
  bsg_tag_packet_tx_if #(.id_w(1), .lg_width_p(4)) if1 ();
  logic tag0, busy0, tag1, busy1;

  bsg_tag_packet_tx #(.els_p(16), .lg_width_p(4), .bit_cycles_p(4), .gap_bits_p(2)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .req_if(if0.slave), .tag_data_o(tag0), .busy_o(busy0));
  bsg_tag_packet_tx #(.els_p(1), .lg_width_p(4), .bit_cycles_p(1), .gap_bits_p(2)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .req_if(if1.slave), .tag_data_o(tag1), .busy_o(busy1));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // per-cycle expected line values and expected busy run length per frame
  bit q0[$];
  bit q1[$];
  int lq0[$];
  int lq1[$];
  int run0 = 0;
  int run1 = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: build the frame as a list of bits, then stretch in time
  task automatic push_frame(input int sel, input int id, input bit dnr,
                            input int len, input logic [14:0] pay);
    int idw = (sel == 0) ? 4 : 1;
    int bc  = (sel == 0) ? 4 : 1;
    bit bits[$];
    bits.push_back(1'b1);
    for (int i = 0; i < idw; i++) bits.push_back(bit'((id >> i) & 1));
    bits.push_back(dnr);
    for (int i = 0; i < 4; i++) bits.push_back(bit'((len >> i) & 1));
    for (int i = 0; i < len; i++) bits.push_back(pay[i]);
    for (int i = 0; i < 2; i++) bits.push_back(1'b0);
    foreach (bits[k]) begin
      for (int r = 0; r < bc; r++) begin
        if (sel == 0) q0.push_back(bits[k]);
        else          q1.push_back(bits[k]);
      end
    end
    if (sel == 0) lq0.push_back(bc * bsg_tag_tx_pkg::frame_bits(idw, 4, len, 2));
    else          lq1.push_back(bc * bsg_tag_tx_pkg::frame_bits(idw, 4, len, 2));
  endtask

  always @(negedge clk) begin
    if (reset_i) run0 = 0;
    else begin
      chk("ready0", if0.ready, logic'(q0.size() == 0));
      chk("busy0", busy0, logic'(q0.size() != 0));
      if (q0.size() != 0) chk("tag0", tag0, q0.pop_front());
      else                chk("idle_tag0", tag0, 1'b0);
      if (busy0) run0++;
      else if (run0 != 0) begin
        chk_int("frame_cycles0", run0, (lq0.size() != 0) ? lq0.pop_front() : -1);
        run0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_i) run1 = 0;
    else begin
      chk("ready1", if1.ready, logic'(q1.size() == 0));
      chk("busy1", busy1, logic'(q1.size() != 0));
      if (q1.size() != 0) chk("tag1", tag1, q1.pop_front());
      else                chk("idle_tag1", tag1, 1'b0);
      if (busy1) run1++;
      else if (run1 != 0) begin
        chk_int("frame_cycles1", run1, (lq1.size() != 0) ? lq1.pop_front() : -1);
        run1 = 0;
      end
    end
  end

  // call at posedge+1; returns at posedge+1 right after the accepting edge, v left high
  task automatic send(input int sel, input int id, input bit dnr, input int len,
                      input logic [14:0] pay, output int hc);
    bit done = 1'b0;
    hc = -1;
    if (sel == 0) begin
      if0.v = 1'b1; if0.id = 4'(id); if0.data_not_reset = dnr;
      if0.len = 4'(len); if0.payload = pay;
    end else begin
      if1.v = 1'b1; if1.id = 1'(id); if1.data_not_reset = dnr;
      if1.len = 4'(len); if1.payload = pay;
    end
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if ((sel == 0) ? if0.ready : if1.ready) begin
        @(posedge clk);
        #1;
        hc = cyc;
        push_frame(sel, id, dnr, len, pay);
        done = 1'b1;
      end
    end
    if (!done) chk("handshake_timeout", 1'b0, 1'b1);
  endtask

  task automatic scramble(input int sel);
    if (sel == 0) begin
      if0.v = 1'b0; if0.id = 4'($urandom); if0.data_not_reset = 1'($urandom);
      if0.len = 4'($urandom); if0.payload = 15'($urandom);
    end else begin
      if1.v = 1'b0; if1.id = 1'($urandom); if1.data_not_reset = 1'($urandom);
      if1.len = 4'($urandom); if1.payload = 15'($urandom);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 500 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h1, h2;
    scramble(0);
    scramble(1);
    repeat (3) @(posedge clk);
    #2 reset_i = 1'b0;
    @(negedge clk);
    chk("reset_ready", if0.ready, 1'b1);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_tag", tag0, 1'b0);
    @(posedge clk); #1;

    // directed frames on the default configuration
    send(0, 5, 1'b1, 3, 15'b101, h1); scramble(0);
    wait_idle();
    send(0, 15, 1'b0, 0, 15'h7fff, h1); scramble(0);
    wait_idle();
    send(0, 9, 1'b1, 15, 15'(16'h5A5A), h1); scramble(0);
    wait_idle();

    // v held high across two requests; second accepted the cycle after the gap
    send(0, 3, 1'b1, 5, 15'h1234, h1);
    send(0, 12, 1'b0, 2, 15'h7ffe, h2);
    scramble(0);
    chk_int("b2b_accept", h2 - h1, 4 * bsg_tag_tx_pkg::frame_bits(4, 4, 5, 2) + 1);
    wait_idle();

    // random frames with junk requests while busy
    for (int i = 0; i < 12; i++) begin
      send(0, int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 15)),
           15'($urandom), h1);
      repeat ($urandom_range(0, 30)) begin
        @(posedge clk); #1;
        if0.v = 1'($urandom); if0.id = 4'($urandom); if0.len = 4'($urandom);
        if0.payload = 15'($urandom); if0.data_not_reset = 1'($urandom);
      end
      scramble(0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    wait_idle();

    // reset in the middle of the payload
    send(0, 6, 1'b1, 15, 15'($urandom), h1); scramble(0);
    repeat (50) @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    chk("midreset_tag", tag0, 1'b0);
    chk("midreset_busy", busy0, 1'b0);
    q0.delete();
    lq0.delete();
    repeat (2) @(posedge clk);
    #2 reset_i = 1'b0;
    @(negedge clk);
    chk("postreset_ready", if0.ready, 1'b1);
    @(posedge clk); #1;
    send(0, 10, 1'b1, 4, 15'b1011, h1); scramble(0);
    wait_idle();

    // one bit per cycle, single-node id
    send(1, 0, 1'b1, 2, 15'b01, h1); scramble(1);
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      send(1, int'($urandom_range(0, 1)), 1'($urandom), int'($urandom_range(0, 15)),
           15'($urandom), h1);
      if ($urandom_range(0, 1) == 1) scramble(1);
    end
    scramble(1);
    wait_idle();

    chk_int("frames_left0", lq0.size(), 0);
    chk_int("frames_left1", lq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
